// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and the MEM stage: queues stores, drains them in FIFO order
// through a two-cycle SETUP/WRITE sequence, gives loads the MEM port. Option: STORE_FWD_EN.
module store_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  input  logic [WIDTH-1:0] st_addr,
  input  logic [WIDTH-1:0] st_data,
  input  logic [2:0]       st_ctrl,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [2:0]       ld_ctrl,
  output logic             ld_stall,
  output logic [WIDTH-1:0] mem_byte_address,
  output logic [WIDTH-1:0] mem_data_write,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic [2:0]       mem_memControl,
  output logic             empty
`ifdef STORE_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [WIDTH-1:0] fwd_data
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Dword size code of the memControl encoding shared with MEM.
  localparam logic [2:0] MEM_DWORD = 3'b011;

  typedef enum logic [1:0] {StIdle, StSetup, StWrite} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [WIDTH-1:0]  addr_mem [DEPTH];
  logic [WIDTH-1:0]  data_mem [DEPTH];
  logic [2:0]        ctrl_mem [DEPTH];

  logic          push, pop, busy, hit, fwd_ok, fwd_take;
  logic [PW-1:0] idx, young_idx;

  assign st_ready = (count_q != CW'(DEPTH));
  assign push     = st_valid && st_ready;
  assign pop      = (state_q == StWrite);
  assign busy     = (state_q != StIdle);
  assign empty    = (count_q == '0) && (state_q == StIdle);

  // Scan oldest to youngest so the last match is the youngest entry.
  always_comb begin
    hit       = 1'b0;
    idx       = '0;
    young_idx = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_mem[idx][WIDTH-1:3] == ld_addr[WIDTH-1:3])) begin
        hit       = 1'b1;
        young_idx = idx;
      end
    end
  end

`ifdef STORE_FWD_EN
  assign fwd_ok    = hit && (ctrl_mem[young_idx] == MEM_DWORD) && (ld_ctrl == MEM_DWORD);
  assign fwd_take  = !rst && ld_valid && !busy && fwd_ok;
  assign fwd_valid = fwd_take;
  assign fwd_data  = fwd_take ? data_mem[young_idx] : '0;
`else
  assign fwd_ok   = 1'b0;
  assign fwd_take = 1'b0;
`endif

  assign ld_stall = !rst && ld_valid && (busy || (hit && !fwd_ok));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if ((count_q != '0) && !(ld_valid && !ld_stall)) state_d = StSetup;
      StSetup: state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while rst is high so the port is quiet before the first clock.
  always_comb begin
    mem_byte_address = '0;
    mem_data_write   = '0;
    mem_memControl   = '0;
    mem_MemRead      = 1'b0;
    mem_MemWrite     = 1'b0;
    if (!rst) begin
      if (busy) begin
        mem_byte_address = addr_mem[rd_ptr_q];
        mem_data_write   = data_mem[rd_ptr_q];
        mem_memControl   = ctrl_mem[rd_ptr_q];
        mem_MemWrite     = (state_q == StWrite);
      end else begin
        mem_byte_address = ld_addr;
        mem_memControl   = ld_ctrl;
        mem_MemRead      = ld_valid && !ld_stall && !fwd_take;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= st_addr;
      data_mem[wr_ptr_q] <= st_data;
      ctrl_mem[wr_ptr_q] <= st_ctrl;
    end
  end

endmodule
